// File: rtl/mult_pkg.sv
// Shared types and sizing for the shift-and-add multiplier controller.
// Holds the state encoding, the default operand width and the counter width.
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Counter must reach WIDTH-1, plus one spare bit for the increment.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(MULT_WIDTH);

endpackage

// File: rtl/shift_add_mult_ctrl_nibble_adder.sv
// WIDTH-bit ripple-carry adder with carry-in tied low.
// Shared by every iteration of the multiplier controller.
module nibble_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    logic carry;

    always_comb begin
        Sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            Sum[i] = A[i] ^ B[i] ^ carry;
            carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Multi-cycle unsigned shift-and-add multiplier with Start/Busy/Done handshake.
// Optional ZERO_BYPASS_EN: zero operands complete on the accepting edge.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] Product,
    output logic               Busy,
    output logic               Done
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   qr_q, qr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH:0]     sel_sum;

    nibble_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .A    (acc_q),
        .B    (m_q),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    // Carry is kept as the new MSB of Acc, so no overflow is possible.
    assign sel_sum = qr_q[0] ? {add_cout, add_sum} : {1'b0, acc_q};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            qr_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        qr_d    = qr_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    m_d   = A;
                    qr_d  = B;
                    acc_d = '0;
                    cnt_d = '0;
`ifdef ZERO_BYPASS_EN
                    if (A == '0 || B == '0) begin
                        prod_d = '0;
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                acc_d = sel_sum[WIDTH:1];
                qr_d  = {sel_sum[0], qr_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    prod_d  = {acc_d, qr_d};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Product = prod_q;
    assign Busy    = (state_q == RUN);
    assign Done    = done_q;

endmodule
